// File: rtl/fft_reorder_sink_if.sv
// rtl/fft_reorder_sink_if.sv - sample stream bundle between FFT output, reorder sink and spectrum consumer.
// Optional do_idx member is present when REORDER_IDX_EN is defined.
interface fft_reorder_sink_if #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             do_sop;
  logic             do_eop;
`ifdef REORDER_IDX_EN
  logic [LOG2N-1:0] do_idx;
`endif

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_sop, do_eop
`ifdef REORDER_IDX_EN
    , input do_idx
`endif
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_sop, do_eop
`ifdef REORDER_IDX_EN
    , output do_idx
`endif
  );
endinterface

// File: rtl/fft_reorder_sink.sv
// rtl/fft_reorder_sink.sv - ping-pong buffer turning bit-reversed FFT output frames into natural order.
// REORDER_IDX_EN adds the do_idx output carrying the natural bin index.
module fft_reorder_sink #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
) (
  input logic              clock,
  input logic              reset,
  fft_reorder_sink_if.slave bus
);
  localparam int N = 1 << LOG2N;

  typedef enum logic {IDLE, READ} state_t;

  state_t             state_q;
  logic [LOG2N-1:0]   wcnt_q;
  logic [LOG2N-1:0]   rcnt_q;
  logic [LOG2N-1:0]   rd_idx_q;
  logic               wb_q;
  logic               rb_q;
  logic [1:0]         full_q;
  logic [1:0]         full_d;
  logic               rd_en_q;
  logic [2*WIDTH-1:0] rdata_q;
  logic [2*WIDTH-1:0] mem [0:2*N-1];
  logic               do_en_q;
  logic               do_sop_q;
  logic               do_eop_q;
  logic [WIDTH-1:0]   do_re_q;
  logic [WIDTH-1:0]   do_im_q;
`ifdef REORDER_IDX_EN
  logic [LOG2N-1:0]   do_idx_q;
`endif

  logic wr_last;
  logic issue;
  logic rd_last;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // IDLE issues address 0 on the same edge it sees a full bank, saving a cycle of latency.
  assign wr_last = bus.di_en && (&wcnt_q);
  assign issue   = (state_q == READ) || full_q[rb_q];
  assign rd_last = issue && (&rcnt_q);

  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wb_q] = 1'b1;
    if (rd_last) full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset && bus.di_en) mem[{wb_q, bitrev(wcnt_q)}] <= {bus.di_re, bus.di_im};
    if (issue) rdata_q <= mem[{rb_q, rcnt_q}];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      rd_idx_q <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      full_q   <= '0;
      rd_en_q  <= 1'b0;
      do_en_q  <= 1'b0;
      do_sop_q <= 1'b0;
      do_eop_q <= 1'b0;
      do_re_q  <= '0;
      do_im_q  <= '0;
`ifdef REORDER_IDX_EN
      do_idx_q <= '0;
`endif
    end else begin
      full_q <= full_d;
      if (bus.di_en) wcnt_q <= wcnt_q + 1'b1;
      if (wr_last) wb_q <= ~wb_q;

      case (state_q)
        IDLE:    if (full_q[rb_q]) state_q <= READ;
        READ:    if (&rcnt_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (issue) begin
        rcnt_q   <= rcnt_q + 1'b1;
        rd_idx_q <= rcnt_q;
      end
      if (rd_last) rb_q <= ~rb_q;
      rd_en_q <= issue;

      do_en_q  <= rd_en_q;
      do_sop_q <= rd_en_q && (rd_idx_q == '0);
      do_eop_q <= rd_en_q && (&rd_idx_q);
      if (rd_en_q) begin
        do_re_q <= rdata_q[2*WIDTH-1:WIDTH];
        do_im_q <= rdata_q[WIDTH-1:0];
`ifdef REORDER_IDX_EN
        do_idx_q <= rd_idx_q;
`endif
      end
    end
  end

  assign bus.do_en  = do_en_q;
  assign bus.do_sop = do_sop_q;
  assign bus.do_eop = do_eop_q;
  assign bus.do_re  = do_re_q;
  assign bus.do_im  = do_im_q;
`ifdef REORDER_IDX_EN
  assign bus.do_idx = do_idx_q;
`endif
endmodule

// File: tb/tb_fft_reorder_sink.sv
// tb/tb_fft_reorder_sink.sv - directed self-checking bench for fft_reorder_sink (REORDER_IDX_EN aware).
module tb_fft_reorder_sink;
  localparam int WIDTH = 16;
  localparam int LOG2N = 6;
  localparam int N = 64;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    logic        eop;
    logic [5:0]  idx;
    int          cyc;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  obs_t q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fft_reorder_sink_if #(.WIDTH(WIDTH), .LOG2N(LOG2N)) bus ();

  fft_reorder_sink #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Output recorder: captures every valid output beat with the edge count it appeared after.
  always @(negedge clock) begin : rec
    obs_t o;
    if (bus.do_en === 1'b1) begin
      o.re  = bus.do_re;
      o.im  = bus.do_im;
      o.sop = bus.do_sop;
      o.eop = bus.do_eop;
`ifdef REORDER_IDX_EN
      o.idx = bus.do_idx;
`else
      o.idx = '0;
`endif
      o.cyc = cyc;
      q.push_back(o);
    end
  end

  function automatic logic [5:0] rev6(input logic [5:0] k);
    return {k[0], k[1], k[2], k[3], k[4], k[5]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] base, input bit gapped, output int t_last);
    t_last = 0;
    for (int m = 0; m < N; m++) begin
      bus.di_en = 1'b1;
      bus.di_re = base + 16'(m);
      bus.di_im = ~(base + 16'(m));
      step();
      t_last = cyc;
      if (gapped) begin
        bus.di_en = 1'b0;
        step();
      end
    end
    bus.di_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    step();
    step();
    n_cmp++;
    if (bus.do_en !== 1'b0 || bus.do_sop !== 1'b0 || bus.do_eop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: en=%b sop=%b eop=%b required 0 0 0", bus.do_en, bus.do_sop, bus.do_eop);
    end
    n_cmp++;
    if (bus.do_re !== 16'h0 || bus.do_im !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data: re=%h im=%h required 0000 0000", bus.do_re, bus.do_im);
    end
`ifdef REORDER_IDX_EN
    n_cmp++;
    if (bus.do_idx !== 6'd0) begin
      n_err++;
      $display("FAIL reset_idx: got %0d required 0", bus.do_idx);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    int t;
    logic [5:0] tbl [8];
    tbl = '{6'd0, 6'd32, 6'd16, 6'd48, 6'd8, 6'd40, 6'd24, 6'd56};
    q.delete();
    send_frame(16'h0000, 1'b0, t);
    repeat (70) step();
    n_cmp++;
    if (q.size() != N) begin
      n_err++;
      $display("FAIL single_count: got %0d beats required %0d", q.size(), N);
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      n_cmp++;
      if (q[k].re !== {10'd0, tbl[k]}) begin
        n_err++;
        $display("FAIL single_table bin %0d: re=%0d required %0d", k, q[k].re, tbl[k]);
      end
    end
    for (int k = 0; k < N && k < q.size(); k++) begin
      n_cmp++;
      if (q[k].re !== {10'd0, rev6(6'(k))} || q[k].im !== ~{10'd0, rev6(6'(k))} ||
          q[k].sop !== (k == 0) || q[k].eop !== (k == N-1) || q[k].cyc !== t + 2 + k) begin
        n_err++;
        $display("FAIL single_bin %0d: re=%h im=%h sop=%b eop=%b cyc=%0d required re=%h sop=%b eop=%b cyc=%0d",
                 k, q[k].re, q[k].im, q[k].sop, q[k].eop, q[k].cyc, {10'd0, rev6(6'(k))}, k == 0, k == N-1, t + 2 + k);
      end
`ifdef REORDER_IDX_EN
      n_cmp++;
      if (q[k].idx !== 6'(k)) begin
        n_err++;
        $display("FAIL single_idx bin %0d: got %0d required %0d", k, q[k].idx, k);
      end
`endif
    end
    n_cmp++;
    if (bus.do_en !== 1'b0 || bus.do_sop !== 1'b0 || bus.do_eop !== 1'b0 ||
        bus.do_re !== 16'd63 || bus.do_im !== ~16'd63) begin
      n_err++;
      $display("FAIL single_hold: en=%b sop=%b eop=%b re=%h im=%h required 0 0 0 003f ffc0",
               bus.do_en, bus.do_sop, bus.do_eop, bus.do_re, bus.do_im);
    end
`ifdef REORDER_IDX_EN
    n_cmp++;
    if (bus.do_idx !== 6'd63) begin
      n_err++;
      $display("FAIL single_idx_hold: got %0d required 63", bus.do_idx);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int t0;
    int t;
    int n_sop;
    int n_eop;
    logic [15:0] exp;
    q.delete();
    send_frame(16'h0000, 1'b0, t0);
    send_frame(16'h0100, 1'b0, t);
    send_frame(16'h0200, 1'b0, t);
    send_frame(16'h0300, 1'b0, t);
    repeat (70) step();
    n_cmp++;
    if (q.size() != 4*N) begin
      n_err++;
      $display("FAIL b2b_count: got %0d beats required %0d", q.size(), 4*N);
    end
    n_sop = 0;
    n_eop = 0;
    for (int i = 0; i < 4*N && i < q.size(); i++) begin
      exp = 16'((i / N) * 256) + {10'd0, rev6(6'(i % N))};
      if (q[i].sop === 1'b1) n_sop++;
      if (q[i].eop === 1'b1) n_eop++;
      n_cmp++;
      if (q[i].re !== exp || q[i].im !== ~exp || q[i].cyc !== t0 + 2 + i ||
          q[i].sop !== (i % N == 0) || q[i].eop !== (i % N == N-1)) begin
        n_err++;
        $display("FAIL b2b_beat %0d: re=%h cyc=%0d sop=%b eop=%b required re=%h cyc=%0d",
                 i, q[i].re, q[i].cyc, q[i].sop, q[i].eop, exp, t0 + 2 + i);
      end
    end
    n_cmp++;
    if (n_sop != 4 || n_eop != 4) begin
      n_err++;
      $display("FAIL b2b_markers: sop=%0d eop=%0d required 4 4", n_sop, n_eop);
    end
  endtask

  task automatic test_gapped();
    int t;
    q.delete();
    send_frame(16'h0000, 1'b1, t);
    repeat (70) step();
    n_cmp++;
    if (q.size() != N) begin
      n_err++;
      $display("FAIL gapped_count: got %0d beats required %0d", q.size(), N);
    end
    for (int k = 0; k < N && k < q.size(); k++) begin
      n_cmp++;
      if (q[k].re !== {10'd0, rev6(6'(k))} || q[k].im !== ~{10'd0, rev6(6'(k))} ||
          q[k].sop !== (k == 0) || q[k].eop !== (k == N-1) || q[k].cyc !== t + 2 + k) begin
        n_err++;
        $display("FAIL gapped_bin %0d: re=%h cyc=%0d required re=%h cyc=%0d",
                 k, q[k].re, q[k].cyc, {10'd0, rev6(6'(k))}, t + 2 + k);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int t;
    q.delete();
    for (int m = 0; m < 20; m++) begin
      bus.di_en = 1'b1;
      bus.di_re = 16'h5500 + 16'(m);
      bus.di_im = 16'h55ff;
      step();
    end
    bus.di_en = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    send_frame(16'h0000, 1'b0, t);
    repeat (70) step();
    n_cmp++;
    if (q.size() != N) begin
      n_err++;
      $display("FAIL rstw_count: got %0d beats required %0d", q.size(), N);
    end
    for (int k = 0; k < N && k < q.size(); k++) begin
      n_cmp++;
      if (q[k].re !== {10'd0, rev6(6'(k))} || q[k].cyc !== t + 2 + k || q[k].sop !== (k == 0)) begin
        n_err++;
        $display("FAIL rstw_bin %0d: re=%h cyc=%0d required re=%h cyc=%0d",
                 k, q[k].re, q[k].cyc, {10'd0, rev6(6'(k))}, t + 2 + k);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int t;
    q.delete();
    send_frame(16'h0200, 1'b0, t);
    repeat (12) step();
    n_cmp++;
    if (bus.do_en !== 1'b1 || bus.do_re !== 16'h0214) begin
      n_err++;
      $display("FAIL rstr_bin10: en=%b re=%h required 1 0214", bus.do_en, bus.do_re);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (bus.do_en !== 1'b0 || bus.do_sop !== 1'b0 || bus.do_eop !== 1'b0 || bus.do_re !== 16'h0) begin
      n_err++;
      $display("FAIL rstr_abort: en=%b sop=%b eop=%b re=%h required 0 0 0 0000",
               bus.do_en, bus.do_sop, bus.do_eop, bus.do_re);
    end
`ifdef REORDER_IDX_EN
    n_cmp++;
    if (bus.do_idx !== 6'd0) begin
      n_err++;
      $display("FAIL rstr_idx: got %0d required 0", bus.do_idx);
    end
`endif
    reset = 1'b1;
    repeat (70) step();
    n_cmp++;
    if (q.size() != 11) begin
      n_err++;
      $display("FAIL rstr_partial: got %0d beats required 11", q.size());
    end
    q.delete();
    send_frame(16'h0300, 1'b0, t);
    repeat (70) step();
    n_cmp++;
    if (q.size() != N) begin
      n_err++;
      $display("FAIL rstr_count: got %0d beats required %0d", q.size(), N);
    end
    for (int k = 0; k < N && k < q.size(); k++) begin
      n_cmp++;
      if (q[k].re !== 16'h0300 + {10'd0, rev6(6'(k))} || q[k].cyc !== t + 2 + k ||
          q[k].sop !== (k == 0) || q[k].eop !== (k == N-1)) begin
        n_err++;
        $display("FAIL rstr_bin %0d: re=%h cyc=%0d required re=%h cyc=%0d",
                 k, q[k].re, q[k].cyc, 16'h0300 + {10'd0, rev6(6'(k))}, t + 2 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_reset_mid_write();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fft_reorder_sink.md
Name: fft_reorder_sink

Overview:
- Output-side companion to FFT64 (R22SDF). Consumes the FFT's bit-reversed-order output stream (do_en/do_re/do_im) and re-emits each N-point frame in natural bin order.
- Uses a ping-pong double buffer so that back-to-back frames stream without stalls.
- Sits between the FFT core and downstream spectrum consumers, which see natural-order frames with start/end markers.

Parameters:
- WIDTH, 16, bit width of the real and imaginary samples.
- LOG2N, 6, log2 of the frame length; N = 2**LOG2N = 64.

Ports:
- clock, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-low.
- di_en, in, 1, input sample valid; connects to FFT do_en.
- di_re, in, WIDTH, input real part, bit-reversed order.
- di_im, in, WIDTH, input imaginary part, bit-reversed order.
- do_en, out, 1, output sample valid.
- do_re, out, WIDTH, output real part, natural order.
- do_im, out, WIDTH, output imaginary part, natural order.
- do_sop, out, 1, high with bin 0 of each output frame.
- do_eop, out, 1, high with bin N-1 of each output frame.

Behaviour:
- Reset: reset sampled low at a rising edge clears all state.
  - do_en, do_sop and do_eop go to 0; do_re and do_im go to 0.
  - Write counter, read counter, write-bank and read-bank selects go to 0.
  - Both bank-full flags are cleared.
  - Buffer RAM contents are not cleared.
  - Reset mid-frame discards the partial frame. Reset mid-readout aborts the frame; do_en is 0 on the next cycle.
- Storage: two banks, each N x 2*WIDTH. The buffer is 2N entries in total.
- Write side:
  - Every edge with di_en=1 writes {di_re,di_im} to bank wb at address bitrev(wcnt), where wcnt is a LOG2N-bit counter.
  - wcnt increments on each accepted sample. Gaps (di_en=0) hold wcnt; gaps of any length are tolerated.
  - On the write with wcnt=N-1: full[wb] is set, wb toggles and wcnt wraps to 0.
- Read side FSM, states IDLE and READ:
  - IDLE -> READ when full[rb]=1. rcnt=0.
  - READ: issue a RAM read of bank rb at address rcnt each cycle and increment rcnt. The RAM read is registered.
  - When rcnt=N-1 is issued: clear full[rb], toggle rb, then go back to IDLE (or re-enter READ if the other bank is already full).
- Output timing:
  - The output register stage is registered on the RAM data.
  - do_en=1 exactly for the N consecutive cycles following each issued read.
  - do_sop accompanies address 0; do_eop accompanies address N-1.
- Latency: with the last input sample of a frame accepted at edge t, bin 0 is on the outputs after edge t+2. Bins follow contiguously, with no bubbles within a frame.
- Continuous input: with di_en held at 1, frames can arrive back-to-back with no gaps. A full bank is always drained before it can be rewritten, so no overflow is possible and there is no backpressure.
- Simultaneous set/clear on the same edge: full[wb] being set and full[rb] being cleared refer to different banks and both take effect.
- When do_en=0: do_re and do_im hold their last value; do_sop and do_eop are 0.

Optional Feature:
- Macro: REORDER_IDX_EN.
- Defined: adds port do_idx, out, LOG2N bits, giving the natural bin index of the current output sample.
  - It is registered alongside do_re, so do_idx = 0..N-1 when do_en=1.
  - Reset value is 0; it holds its value when do_en=0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Single frame: 64 samples with di_re=m and di_im=~m, where m=0..63 is the arrival index.
  - Expected: do_re sequence 0,32,16,48,8,40,...,63 (that is, bitrev(k)), and do_im equal to the complement of each.
  - First do_en occurs 2 cycles after the last di_en; do_sop only at k=0; do_eop only at k=63.
- Back-to-back: 4 frames with di_en held at 1 for 256 cycles.
  - Expected: do_en high for 256 contiguous cycles with correct per-frame order and exactly 4 sop/eop pairs.
- Gapped input: di_en toggling 1,0,1,0 across one frame.
  - Expected: the output frame is identical to the single-frame case, and output is contiguous after the frame completes.
- Reset mid-write: reset low for 1 cycle after 20 samples, then a full new frame.
  - Expected: only the new frame is output; the 20 stale samples never appear.
- Reset mid-read: reset asserted at output bin 10.
  - Expected: do_en, do_sop and do_eop are 0 on the next cycle; the next complete input frame is output starting at bin 0.
- REORDER_IDX_EN defined, single frame:
  - Expected: do_idx counts 0..63 in lockstep with do_en and is 0 after reset.
